// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions/interrupts, captures mepc/mcause,
// redirects fetch to mtvec, and restores fetch to mepc on mret.
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
    parameter int          IRQ_SYNC  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ext_irq,
    input  logic        i_excep,
    input  logic [3:0]  i_excep_cause,
    input  logic        i_mret,
    input  logic        i_stall,
    input  logic [31:0] i_pc4save,
    input  logic        i_csr_we,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    output logic        o_intr,
    output logic        o_excep_ack,
    output logic        o_flush,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_in_trap,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_RETURN  = 2'd2
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t                r_state;
    state_t                w_next_state;
    logic [IRQ_SYNC-1:0]   r_irq_sync;
    logic                  r_mie;
    logic                  r_mpie;
    logic                  r_in_trap;
    logic [31:0]           r_mepc;
    logic [31:0]           r_mcause;
    logic [31:0]           r_mtvec;
    logic [31:0]           r_cause_q;
    logic [31:0]           w_cause_next;
    logic                  w_irq_s;
    logic                  w_irq_take;
    logic                  w_unused;

    assign w_irq_s     = r_irq_sync[IRQ_SYNC-1];
    assign w_irq_take  = w_irq_s & r_mie & ~i_stall & (r_state == S_IDLE);
    assign o_in_trap   = r_in_trap;
    assign o_dbg_state = r_state;
    assign w_unused    = &{1'b0, i_pc4save[1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_sync <= '0;
        end else begin
            r_irq_sync <= {r_irq_sync[IRQ_SYNC-2:0], i_ext_irq};
        end
    end

    // Priority in IDLE: exception, then mret, then interrupt.
    always_comb begin
        w_next_state  = r_state;
        w_cause_next  = r_cause_q;
        o_intr        = 1'b0;
        o_excep_ack   = 1'b0;
        o_flush       = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (i_excep) begin
                    o_excep_ack  = 1'b1;
                    o_flush      = 1'b1;
                    w_cause_next = {28'h0, i_excep_cause};
                    w_next_state = S_CAPTURE;
                end else if (i_mret) begin
                    o_flush      = 1'b1;
                    w_next_state = S_RETURN;
                end else if (w_irq_take) begin
                    o_intr       = 1'b1;
                    o_flush      = 1'b1;
                    w_cause_next = 32'h8000_000B;
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                o_redirect    = 1'b1;
                o_redirect_pc = r_mtvec;
                o_flush       = 1'b1;
                w_next_state  = S_IDLE;
            end
            S_RETURN: begin
                o_redirect    = 1'b1;
                o_redirect_pc = r_mepc;
                w_next_state  = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cause_q <= 32'h0;
        end else begin
            r_state   <= w_next_state;
            r_cause_q <= w_cause_next;
        end
    end

    // Trap bookkeeping owns the CSRs outside IDLE, so software writes there are dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mie     <= 1'b0;
            r_mpie    <= 1'b0;
            r_in_trap <= 1'b0;
            r_mepc    <= 32'h0;
            r_mcause  <= 32'h0;
            r_mtvec   <= {MTVEC_RST[31:2], 2'b00};
        end else if (r_state == S_CAPTURE) begin
            r_mepc    <= {i_pc4save[31:2], 2'b00};
            r_mcause  <= r_cause_q;
            r_mpie    <= r_mie;
            r_mie     <= 1'b0;
            r_in_trap <= 1'b1;
        end else if (r_state == S_RETURN) begin
            r_mie     <= r_mpie;
            r_mpie    <= 1'b1;
            r_in_trap <= 1'b0;
        end else if (i_csr_we) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= i_csr_wdata[3];
                    r_mpie <= i_csr_wdata[7];
                end
                CSR_MTVEC:  r_mtvec  <= {i_csr_wdata[31:2], 2'b00};
                CSR_MEPC:   r_mepc   <= {i_csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: r_mcause <= i_csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_csr_rdata = 32'h0;
        case (i_csr_addr)
            CSR_MSTATUS: o_csr_rdata = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
            CSR_MTVEC:   o_csr_rdata = r_mtvec;
            CSR_MEPC:    o_csr_rdata = r_mepc;
            CSR_MCAUSE:  o_csr_rdata = r_mcause;
            default:     o_csr_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural trap/CSR model.
module tb_trap_ctrl;

    localparam int          IRQ_SYNC  = 2;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_ext_irq;
    logic        i_excep;
    logic [3:0]  i_excep_cause;
    logic        i_mret;
    logic        i_stall;
    logic [31:0] i_pc4save;
    logic        i_csr_we;
    logic [11:0] i_csr_addr;
    logic [31:0] i_csr_wdata;
    logic [31:0] o_csr_rdata;
    logic        o_intr;
    logic        o_excep_ack;
    logic        o_flush;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_in_trap;
    logic [1:0]  o_dbg_state;

    trap_ctrl #(.MTVEC_RST(MTVEC_RST), .IRQ_SYNC(IRQ_SYNC)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_ext_irq(i_ext_irq),
        .i_excep(i_excep), .i_excep_cause(i_excep_cause), .i_mret(i_mret),
        .i_stall(i_stall), .i_pc4save(i_pc4save), .i_csr_we(i_csr_we),
        .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata),
        .o_csr_rdata(o_csr_rdata), .o_intr(o_intr), .o_excep_ack(o_excep_ack),
        .o_flush(o_flush), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_in_trap(o_in_trap), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = free, 1 = entering trap, 2 = returning.
    int          m_phase;
    bit          m_mie, m_mpie, m_in_trap;
    logic [31:0] m_mepc, m_mcause, m_mtvec, m_cause_q;
    bit          irq_q[$];
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mie = 0; m_mpie = 0; m_in_trap = 0;
        m_mepc = 0; m_mcause = 0; m_mtvec = MTVEC_RST & ~32'h3; m_cause_q = 0;
        irq_q.delete();
        for (int i = 0; i < IRQ_SYNC; i++) irq_q.push_back(1'b0);
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_csr(input logic [11:0] addr);
        case (addr)
            12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_take();
        return irq_q[0] && m_mie && !i_stall && (m_phase == 0);
    endfunction

    task automatic compare_all();
        bit idle, e_ack, e_ret, e_intr;
        logic [31:0] want_pc;
        idle   = (m_phase == 0);
        e_ack  = idle && i_excep;
        e_ret  = idle && !i_excep && i_mret;
        e_intr = !i_excep && !i_mret && model_take();
        check_eq("intr", {31'h0, o_intr}, {31'h0, e_intr});
        check_eq("excep_ack", {31'h0, o_excep_ack}, {31'h0, e_ack});
        check_eq("flush", {31'h0, o_flush}, {31'h0, e_ack | e_ret | e_intr | (m_phase == 1)});
        check_eq("redirect", {31'h0, o_redirect}, {31'h0, m_phase != 0});
        check_eq("in_trap", {31'h0, o_in_trap}, {31'h0, m_in_trap});
        check_eq("csr_rdata", o_csr_rdata, model_csr(i_csr_addr));
        if (o_redirect) begin
            if (exp_q.size() == 0) begin
                check_eq("redirect_unexpected", o_redirect_pc, 32'hFFFF_FFFF);
            end else begin
                want_pc = exp_q.pop_front();
                check_eq("redirect_pc", o_redirect_pc, want_pc);
            end
        end
    endtask

    task automatic model_update();
        bit take;
        take = model_take();
        if (m_phase == 1) begin
            m_mepc = i_pc4save & ~32'h3;
            m_mcause = m_cause_q;
            m_mpie = m_mie;
            m_mie = 0;
            m_in_trap = 1;
            m_phase = 0;
        end else if (m_phase == 2) begin
            m_mie = m_mpie;
            m_mpie = 1;
            m_in_trap = 0;
            m_phase = 0;
        end else begin
            if (i_csr_we) begin
                case (i_csr_addr)
                    12'h300: begin m_mie = i_csr_wdata[3]; m_mpie = i_csr_wdata[7]; end
                    12'h305: m_mtvec = i_csr_wdata & ~32'h3;
                    12'h341: m_mepc = i_csr_wdata & ~32'h3;
                    12'h342: m_mcause = i_csr_wdata;
                    default: ;
                endcase
            end
            if (i_excep) begin
                m_cause_q = {28'h0, i_excep_cause};
                m_phase = 1;
                exp_q.push_back(m_mtvec);
            end else if (i_mret) begin
                m_phase = 2;
                exp_q.push_back(m_mepc);
            end else if (take) begin
                m_cause_q = 32'h8000_000B;
                m_phase = 1;
                exp_q.push_back(m_mtvec);
            end
        end
        irq_q.push_back(i_ext_irq);
        void'(irq_q.pop_front());
    endtask

    // Called at posedge+1..+2; checks the cycle, advances the model, returns at next posedge+1.
    task automatic tick();
        #2;
        compare_all();
        if (!i_rst_n) model_reset();
        else model_update();
        @(posedge clk);
        #1;
        i_excep = 0;
        i_mret = 0;
        i_csr_we = 0;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        i_csr_we = 1; i_csr_addr = addr; i_csr_wdata = data;
        tick();
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        i_csr_addr = addr;
        #1;
        check_eq(tag, o_csr_rdata, exp);
        tick();
    endtask

    initial begin
        i_rst_n = 0; i_ext_irq = 1; i_excep = 0; i_excep_cause = 0; i_mret = 0;
        i_stall = 0; i_pc4save = 0; i_csr_we = 0; i_csr_addr = 12'h305; i_csr_wdata = 0;
        model_reset();
        @(posedge clk); #1;

        // Reset held with irq high
        repeat (3) tick();
        #1;
        check_eq("rst_intr", {31'h0, o_intr}, 32'h0);
        check_eq("rst_flush", {31'h0, o_flush}, 32'h0);
        check_eq("rst_redirect", {31'h0, o_redirect}, 32'h0);
        check_eq("rst_ack", {31'h0, o_excep_ack}, 32'h0);
        check_eq("rst_mtvec", o_csr_rdata, 32'h0000_0100);
        i_rst_n = 1;
        repeat (6) begin #1; check_eq("no_intr_mie0", {31'h0, o_intr}, 32'h0); tick(); end

        // Interrupt entry latency and capture
        i_ext_irq = 0;
        repeat (3) tick();
        csr_wr(12'h300, 32'h8);
        i_ext_irq = 1;
        repeat (IRQ_SYNC) begin #1; check_eq("irq_early", {31'h0, o_intr}, 32'h0); tick(); end
        #1;
        check_eq("irq_intr", {31'h0, o_intr}, 32'h1);
        check_eq("irq_flush", {31'h0, o_flush}, 32'h1);
        tick();
        i_pc4save = 32'h0000_0A46;
        i_csr_we = 1; i_csr_addr = 12'h341; i_csr_wdata = 32'hDEAD_BEEC;
        #1;
        check_eq("cap_redirect", {31'h0, o_redirect}, 32'h1);
        check_eq("cap_pc", o_redirect_pc, 32'h0000_0100);
        tick();
        i_csr_addr = 12'h341;
        #1;
        check_eq("in_trap_set", {31'h0, o_in_trap}, 32'h1);
        check_eq("mepc_cap", o_csr_rdata, 32'h0000_0A44);
        tick();
        rd("mcause_irq", 12'h342, 32'h8000_000B);
        rd("mstatus_trap", 12'h300, 32'h0000_0080);

        // mret with pending irq
        csr_wr(12'h341, 32'h200);
        i_mret = 1;
        #1;
        check_eq("mret_flush", {31'h0, o_flush}, 32'h1);
        check_eq("mret_no_redirect", {31'h0, o_redirect}, 32'h0);
        tick();
        #1;
        check_eq("ret_redirect", {31'h0, o_redirect}, 32'h1);
        check_eq("ret_pc", o_redirect_pc, 32'h0000_0200);
        tick();
        i_csr_addr = 12'h300;
        #1;
        check_eq("ret_in_trap", {31'h0, o_in_trap}, 32'h0);
        check_eq("ret_mstatus", o_csr_rdata, 32'h0000_0088);
        check_eq("retake_intr", {31'h0, o_intr}, 32'h1);
        tick();
        tick();

        // Stall blocks interrupt
        i_stall = 1;
        csr_wr(12'h300, 32'h8);
        repeat (5) begin #1; check_eq("stall_no_intr", {31'h0, o_intr}, 32'h0); tick(); end
        i_stall = 0;
        #1;
        check_eq("unstall_intr", {31'h0, o_intr}, 32'h1);
        tick();
        tick();

        // Exception beats interrupt; exception taken with MIE=0
        csr_wr(12'h300, 32'h8);
        i_excep = 1; i_excep_cause = 4'd2;
        #1;
        check_eq("tie_ack", {31'h0, o_excep_ack}, 32'h1);
        check_eq("tie_intr", {31'h0, o_intr}, 32'h0);
        tick();
        tick();
        rd("mcause_exc2", 12'h342, 32'h0000_0002);
        i_ext_irq = 0;
        i_excep = 1; i_excep_cause = 4'd5;
        #1;
        check_eq("exc_mie0_ack", {31'h0, o_excep_ack}, 32'h1);
        tick();
        tick();
        rd("mcause_exc5", 12'h342, 32'h0000_0005);

        // Reset during RETURN
        csr_wr(12'h305, 32'h0000_0403);
        rd("mtvec_wr", 12'h305, 32'h0000_0400);
        i_mret = 1;
        tick();
        i_csr_addr = 12'h305;
        #1;
        check_eq("pre_rst_redirect", {31'h0, o_redirect}, 32'h1);
        i_rst_n = 0;
        model_reset();
        #1;
        check_eq("midrst_redirect", {31'h0, o_redirect}, 32'h0);
        check_eq("midrst_mtvec", o_csr_rdata, 32'h0000_0100);
        tick();
        i_rst_n = 1;
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) i_ext_irq = ~i_ext_irq;
            i_stall       = ($urandom_range(0, 3) == 0);
            i_excep       = ($urandom_range(0, 9) == 0);
            i_excep_cause = 4'($urandom_range(0, 15));
            i_mret        = ($urandom_range(0, 9) == 0);
            i_pc4save     = $urandom;
            i_csr_we      = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 4))
                0: i_csr_addr = 12'h300;
                1: i_csr_addr = 12'h305;
                2: i_csr_addr = 12'h341;
                3: i_csr_addr = 12'h342;
                default: i_csr_addr = 12'($urandom_range(0, 4095));
            endcase
            i_csr_wdata = ($urandom_range(0, 1) == 0) ? 32'h88 : $urandom;
            if ($urandom_range(0, 299) == 0) begin
                i_rst_n = 0;
                model_reset();
                tick();
                i_rst_n = 1;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
